// File: rtl/core_lsu.sv
// Load/store unit: single-outstanding req/ack data-memory transaction with
// byte-lane steering, load extension, misalignment and bus-timeout detection.
module core_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_lb,
  input  logic        i_lh,
  input  logic        i_lw,
  input  logic        i_lbu,
  input  logic        i_lhu,
  input  logic        i_sb,
  input  logic        i_sh,
  input  logic        i_sw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_rd,
  output logic        o_misalign,
  output logic        o_bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FIN} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_is_load, w_is_load;
  logic [1:0]    r_size, w_size;
  logic          r_sext, w_sext;
  logic [1:0]    r_lane, w_lane;
  logic          r_mem_req, w_mem_req;
  logic          r_mem_we, w_mem_we;
  logic [31:0]   r_mem_addr, w_mem_addr;
  logic [3:0]    r_mem_be, w_mem_be;
  logic [31:0]   r_mem_wdata, w_mem_wdata;
  logic          r_done, w_done;
  logic [31:0]   r_load_data, w_load_data;
  logic          r_wb_en, w_wb_en;
  logic [4:0]    r_wb_rd, w_wb_rd;
  logic          r_misalign, w_misalign;
  logic          r_bus_err, w_bus_err;

  logic [7:0]    w_ops;
  logic          w_st_load;
  logic [1:0]    w_st_size;
  logic          w_st_mis;
  logic [3:0]    w_st_be;
  logic [31:0]   w_st_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ext;

  // Decode of the op presented with START (size: 0 byte, 1 half, 2 word)
  assign w_ops     = {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb};
  assign w_st_load = i_lb | i_lh | i_lw | i_lbu | i_lhu;
  assign w_st_size = (i_lw | i_sw) ? 2'd2 : ((i_lh | i_lhu | i_sh) ? 2'd1 : 2'd0);

  always_comb begin
    w_st_mis   = 1'b0;
    w_st_be    = 4'b0001 << i_addr[1:0];
    w_st_wdata = {4{i_wdata[7:0]}};
    case (w_st_size)
      2'd1: begin
        w_st_mis   = i_addr[0];
        w_st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{i_wdata[15:0]}};
      end
      2'd2: begin
        w_st_mis   = |i_addr[1:0];
        w_st_be    = 4'b1111;
        w_st_wdata = i_wdata;
      end
      default: ;
    endcase
    if (w_st_load) w_st_wdata = '0;
  end

  // Lane select and extension of the returning read word
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      2'd0:    w_ext = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_ext = {{16{r_sext & w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_is_load   = r_is_load;
    w_size      = r_size;
    w_sext      = r_sext;
    w_lane      = r_lane;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_be    = r_mem_be;
    w_mem_wdata = r_mem_wdata;
    w_load_data = r_load_data;
    w_wb_rd     = r_wb_rd;
    w_done      = 1'b0;
    w_wb_en     = 1'b0;
    w_misalign  = 1'b0;
    w_bus_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && $onehot(w_ops)) begin
          w_wb_rd   = i_rd;
          w_is_load = w_st_load;
          w_size    = w_st_size;
          w_sext    = i_lb | i_lh;
          w_lane    = i_addr[1:0];
          w_cnt     = '0;
          if (w_st_mis) begin
            w_state    = S_FIN;
            w_done     = 1'b1;
            w_misalign = 1'b1;
          end else begin
            w_state     = S_REQ;
            w_mem_req   = 1'b1;
            w_mem_we    = ~w_st_load;
            w_mem_addr  = {i_addr[31:2], 2'b00};
            w_mem_be    = w_st_be;
            w_mem_wdata = w_st_wdata;
          end
        end
      end
      S_REQ: begin
        if (i_mem_ack) begin
          w_state   = S_FIN;
          w_mem_req = 1'b0;
          w_done    = 1'b1;
          if (r_is_load) begin
            w_wb_en     = 1'b1;
            w_load_data = w_ext;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_state   = S_FIN;
          w_mem_req = 1'b0;
          w_done    = 1'b1;
          w_bus_err = 1'b1;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_FIN:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_load   <= 1'b0;
      r_size      <= '0;
      r_sext      <= 1'b0;
      r_lane      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_load_data <= '0;
      r_wb_en     <= 1'b0;
      r_wb_rd     <= '0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_is_load   <= w_is_load;
      r_size      <= w_size;
      r_sext      <= w_sext;
      r_lane      <= w_lane;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_be    <= w_mem_be;
      r_mem_wdata <= w_mem_wdata;
      r_done      <= w_done;
      r_load_data <= w_load_data;
      r_wb_en     <= w_wb_en;
      r_wb_rd     <= w_wb_rd;
      r_misalign  <= w_misalign;
      r_bus_err   <= w_bus_err;
    end
  end

  // Busy is registered alongside the state so it follows an async reset
  logic r_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= (w_state != S_IDLE);
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_load_data = r_load_data;
  assign o_wb_en     = r_wb_en;
  assign o_wb_rd     = r_wb_rd;
  assign o_misalign  = r_misalign;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_core_lsu.sv
// Directed plus randomized bench for core_lsu against a byte-arithmetic model.
module tb_core_lsu;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_lb = 1'b0, i_lh = 1'b0, i_lw = 1'b0, i_lbu = 1'b0;
  logic        i_lhu = 1'b0, i_sb = 1'b0, i_sh = 1'b0, i_sw = 1'b0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [4:0]  i_rd = '0;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_busy, o_done, o_wb_en, o_misalign, o_bus_err;
  logic [31:0] o_load_data;
  logic [4:0]  o_wb_rd;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_ld = '0;
  logic [4:0]  exp_rd = '0;

  core_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start),
    .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu), .i_lhu(i_lhu),
    .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_load_data(o_load_data),
    .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_misalign(o_misalign),
    .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  // Op codes: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW
  function automatic int nbytes(input int op);
    if (op == 0 || op == 3 || op == 5) return 1;
    if (op == 1 || op == 4 || op == 6) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] lowmask(input int n);
    if (n == 4) return 32'hFFFF_FFFF;
    return 32'((64'd1 << (8 * n)) - 64'd1);
  endfunction

  function automatic logic [3:0] model_be(input int op, input logic [31:0] a);
    int n;
    n = nbytes(op);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wd(input int op, input logic [31:0] wd);
    int n;
    logic [31:0] r;
    if (op < 5) return 32'h0;
    n = nbytes(op);
    r = '0;
    for (int i = 0; i < 4; i += n) r = r | ((wd & lowmask(n)) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] model_ld(input int op, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = nbytes(op);
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) & lowmask(n);
    if ((op == 0 || op == 1) && v[8 * n - 1]) v = v | ~lowmask(n);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [7:0] f);
    {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb} = f;
  endtask

  // waits < 0 means the bus never acknowledges
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input int waits,
                        input logic [31:0] rdata, input bit poke);
    bit ld, mis;
    int c, exp_c;
    ld  = (op < 5);
    mis = ((a % 4) % nbytes(op)) != 0;
    @(negedge clk);
    i_start = 1'b1; set_flags(8'(1 << op));
    i_addr = a; i_wdata = wd; i_rd = rd;
    @(negedge clk);
    i_start = 1'b0; set_flags(8'h00);
    i_addr = $urandom; i_wdata = $urandom; i_rd = 5'($urandom);
    exp_rd = rd;
    if (mis) begin
      chk("mis_req", 32'(o_mem_req), 32'd0);
      chk("mis_done", 32'(o_done), 32'd1);
      chk("mis_flag", 32'(o_misalign), 32'd1);
      chk("mis_wb_en", 32'(o_wb_en), 32'd0);
      chk("mis_bus_err", 32'(o_bus_err), 32'd0);
    end else begin
      c = 0;
      while (o_done !== 1'b1 && c < 40) begin
        chk("req_high", 32'(o_mem_req), 32'd1);
        chk("req_busy", 32'(o_busy), 32'd1);
        chk("req_we", 32'(o_mem_we), 32'(!ld));
        chk("req_addr", o_mem_addr, a & 32'hFFFF_FFFC);
        chk("req_be", 32'(o_mem_be), 32'(model_be(op, a)));
        chk("req_wdata", o_mem_wdata, model_wd(op, wd));
        i_mem_ack   = (c == waits);
        i_mem_rdata = (c == waits) ? rdata : $urandom;
        if (poke && c == 0) begin
          i_start = 1'b1; i_sw = 1'b1; i_addr = 32'h40;
        end
        @(negedge clk);
        i_mem_ack = 1'b0; i_start = 1'b0; i_sw = 1'b0;
        c++;
      end
      exp_c = (waits < 0) ? int'(TO) : waits + 1;
      chk("req_cycles", 32'(c), 32'(exp_c));
      chk("fin_done", 32'(o_done), 32'd1);
      chk("fin_req", 32'(o_mem_req), 32'd0);
      chk("fin_misalign", 32'(o_misalign), 32'd0);
      chk("fin_bus_err", 32'(o_bus_err), 32'(waits < 0));
      chk("fin_wb_en", 32'(o_wb_en), 32'(ld && waits >= 0));
      if (ld && waits >= 0) exp_ld = model_ld(op, a, rdata);
      chk("fin_load_data", o_load_data, exp_ld);
    end
    chk("fin_wb_rd", 32'(o_wb_rd), 32'(exp_rd));
    @(negedge clk);
    chk("post_done", 32'(o_done), 32'd0);
    chk("post_busy", 32'(o_busy), 32'd0);
    chk("post_req", 32'(o_mem_req), 32'd0);
    chk("post_wb_en", 32'(o_wb_en), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_load_data", o_load_data, 32'd0);
    chk("rst_wb_rd", 32'(o_wb_rd), 32'd0);
    rst_n = 1'b1;

    run_op(2, 32'h0000_0100, 32'h0, 5'd5, 2, 32'hDEAD_BEEF, 1'b0);
    run_op(0, 32'h0000_0203, 32'h0, 5'd7, 0, 32'h8012_3456, 1'b0);
    chk("lb_value", o_load_data, 32'hFFFF_FF80);
    run_op(3, 32'h0000_0203, 32'h0, 5'd8, 1, 32'h8012_3456, 1'b0);
    chk("lbu_value", o_load_data, 32'h0000_0080);
    run_op(4, 32'h0000_0202, 32'h0, 5'd9, 0, 32'h8012_3456, 1'b0);
    chk("lhu_value", o_load_data, 32'h0000_8012);
    run_op(6, 32'h0000_0102, 32'h1234_ABCD, 5'd10, 0, 32'h5555_5555, 1'b0);
    chk("sh_keeps_load_data", o_load_data, 32'h0000_8012);
    run_op(2, 32'h0000_0102, 32'h0, 5'd11, 0, 32'h0, 1'b0);
    run_op(6, 32'h0000_0101, 32'hFFFF_FFFF, 5'd12, 0, 32'h0, 1'b0);

    run_op(7, 32'h0000_0400, 32'hCAFE_F00D, 5'd13, -1, 32'h0, 1'b0);
    i_mem_ack = 1'b1;
    @(negedge clk);
    i_mem_ack = 1'b0;
    chk("late_ack_busy", 32'(o_busy), 32'd0);
    chk("late_ack_done", 32'(o_done), 32'd0);
    chk("late_ack_req", 32'(o_mem_req), 32'd0);

    // Reset while a request is outstanding
    @(negedge clk);
    i_start = 1'b1; i_lw = 1'b1; i_addr = 32'h300; i_rd = 5'd14;
    @(negedge clk);
    i_start = 1'b0; i_lw = 1'b0;
    chk("mid_req_high", 32'(o_mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(o_mem_req), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_ld = '0; exp_rd = '0;
    chk("mid_rst_load_data", o_load_data, exp_ld);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_done", 32'(o_done), 32'd0);
      chk("mid_rst_idle", 32'(o_busy), 32'd0);
    end

    // Ambiguous or empty op selects are ignored
    @(negedge clk);
    i_start = 1'b1; i_lw = 1'b1; i_sw = 1'b1; i_addr = 32'h500;
    @(negedge clk);
    i_start = 1'b0; i_lw = 1'b0; i_sw = 1'b0;
    chk("multi_busy", 32'(o_busy), 32'd0);
    chk("multi_req", 32'(o_mem_req), 32'd0);
    chk("multi_done", 32'(o_done), 32'd0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("none_busy", 32'(o_busy), 32'd0);
    chk("none_done", 32'(o_done), 32'd0);

    run_op(2, 32'h0000_0500, 32'h0, 5'd15, 3, 32'h0BAD_CAFE, 1'b1);
    @(negedge clk);
    chk("poke_no_second_req", 32'(o_mem_req), 32'd0);
    chk("poke_no_second_busy", 32'(o_busy), 32'd0);

    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom),
             int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
